falafel_req_frontend: RTL and testbench

- Request front-end for the Falafel allocator, sitting between the host request port and the allocator core.
- Decodes opcodes (0 access register, 1 alloc, 2 free) and serves register accesses locally from a parametrised config register file.
- Aligns alloc sizes and forwards alloc/free to the core over a valid/ready handshake.
- Returns exactly one response per request. One request in flight at a time.

---
 rtl/falafel_req_frontend.sv | 222 ++++++++++++++++++++++
 tb/tb_falafel_req_frontend.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/falafel_req_frontend.sv
// rtl/falafel_req_frontend.sv - Falafel allocator request front-end
// Optional statistics counters are built when FALAFEL_REQ_STATS_EN is defined.
module falafel_req_frontend #(
  parameter int unsigned       DATA_W        = 64,
  parameter int unsigned       NUM_CFG_REGS  = 4,
  parameter logic [DATA_W-1:0] CFG_BASE_ADDR = DATA_W'('h10),
  parameter int unsigned       ALIGNMENT     = 8,
  parameter int unsigned       MIN_PAYLOAD   = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [DATA_W-1:0]              req_opcode_i,
  input  logic [DATA_W-1:0]              req_addr_i,
  input  logic                           req_we_i,
  input  logic [DATA_W-1:0]              req_data_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [DATA_W-1:0]              rsp_data_o,
  output logic                           rsp_err_o,
  output logic                           core_valid_o,
  input  logic                           core_ready_i,
  output logic                           core_is_free_o,
  output logic [DATA_W-1:0]              core_arg_o,
  input  logic                           core_done_i,
  input  logic [DATA_W-1:0]              core_result_i,
  output logic [NUM_CFG_REGS*DATA_W-1:0] cfg_regs_o,
  input  logic                           cfg_flp_we_i,
  input  logic [DATA_W-1:0]              cfg_flp_i
);

  localparam int unsigned       SUM_W      = DATA_W + 1;
  localparam logic [SUM_W-1:0]  ALIGN_ADD  = SUM_W'(ALIGNMENT - 1);
  localparam logic [SUM_W-1:0]  ALIGN_MASK = ~ALIGN_ADD;
  localparam logic [DATA_W-1:0] MIN_SIZE   = DATA_W'(MIN_PAYLOAD);
  localparam logic [DATA_W-1:0] ALL_ONES   = '1;
  localparam logic [DATA_W-1:0] OP_REG     = '0;
  localparam logic [DATA_W-1:0] OP_ALLOC   = DATA_W'(1);
  localparam logic [DATA_W-1:0] OP_FREE    = DATA_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_CORE_ISSUE, S_CORE_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_cfg [NUM_CFG_REGS];
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_core_arg;
  logic              r_core_is_free;

  logic              w_accept;
  logic [DATA_W-1:0] w_offset;
  logic [DATA_W-1:0] w_idx;
  logic              w_addr_ok;
  logic              w_cfg_hit;
  logic              w_cfg_we;
  logic [DATA_W-1:0] w_cfg_rdata;
  logic [DATA_W-1:0] w_size;
  logic [SUM_W-1:0]  w_aligned;
  logic              w_go_core;

  assign w_accept  = (r_state == S_IDLE) && req_valid_i;
  assign w_offset  = req_addr_i - CFG_BASE_ADDR;
  assign w_idx     = w_offset >> 3;
  assign w_addr_ok = (req_addr_i >= CFG_BASE_ADDR) && (w_offset[2:0] == 3'b000);
  assign w_cfg_hit = w_addr_ok && (w_idx < DATA_W'(NUM_CFG_REGS));
  assign w_cfg_we  = w_accept && (req_opcode_i == OP_REG) && req_we_i && w_cfg_hit;

  // Extra top bit catches the carry when rounding a near-max size up.
  assign w_size    = (req_data_i < MIN_SIZE) ? MIN_SIZE : req_data_i;
  assign w_aligned = ({1'b0, w_size} + ALIGN_ADD) & ALIGN_MASK;
  assign w_go_core = ((req_opcode_i == OP_ALLOC) && !w_aligned[DATA_W]) ||
                     ((req_opcode_i == OP_FREE) && (req_data_i != '0));

  always_comb begin
    w_cfg_rdata = '0;
    for (int i = 0; i < NUM_CFG_REGS; i++) begin
      if (w_idx == DATA_W'(i)) w_cfg_rdata = r_cfg[i];
    end
  end

`ifdef FALAFEL_REQ_STATS_EN
  typedef enum logic [1:0] {K_OTHER, K_ALLOC, K_FREE} kind_t;

  kind_t             r_kind;
  logic [DATA_W-1:0] r_alloc_ok;
  logic [DATA_W-1:0] r_free_ok;
  logic [DATA_W-1:0] r_nomem;
  logic              w_stat_hit;
  logic [DATA_W-1:0] w_stat_rdata;

  assign w_stat_hit = w_addr_ok && (w_idx >= DATA_W'(NUM_CFG_REGS)) &&
                      (w_idx < DATA_W'(NUM_CFG_REGS + 3));

  always_comb begin
    w_stat_rdata = r_nomem;
    if (w_idx == DATA_W'(NUM_CFG_REGS))          w_stat_rdata = r_alloc_ok;
    else if (w_idx == DATA_W'(NUM_CFG_REGS + 1)) w_stat_rdata = r_free_ok;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_kind     <= K_OTHER;
      r_alloc_ok <= '0;
      r_free_ok  <= '0;
      r_nomem    <= '0;
    end else begin
      if (w_accept) begin
        if (req_opcode_i == OP_ALLOC)     r_kind <= K_ALLOC;
        else if (req_opcode_i == OP_FREE) r_kind <= K_FREE;
        else                              r_kind <= K_OTHER;
      end
      if ((r_state == S_RESP) && rsp_ready_i) begin
        if (r_kind == K_FREE)                     r_free_ok  <= r_free_ok + 1'b1;
        else if ((r_kind == K_ALLOC) && r_rsp_err) r_nomem    <= r_nomem + 1'b1;
        else if (r_kind == K_ALLOC)                r_alloc_ok <= r_alloc_ok + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    req_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    core_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_state_nxt = w_go_core ? S_CORE_ISSUE : S_RESP;
      end
      S_CORE_ISSUE: begin
        core_valid_o = 1'b1;
        if (core_ready_i) w_state_nxt = core_done_i ? S_RESP : S_CORE_WAIT;
      end
      S_CORE_WAIT: begin
        if (core_done_i) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rsp_data     <= '0;
      r_rsp_err      <= 1'b0;
      r_core_arg     <= '0;
      r_core_is_free <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            if (req_opcode_i == OP_REG) begin
              if (w_cfg_hit) begin
                if (!req_we_i) r_rsp_data <= w_cfg_rdata;
              end
`ifdef FALAFEL_REQ_STATS_EN
              else if (w_stat_hit && !req_we_i) r_rsp_data <= w_stat_rdata;
`endif
              else r_rsp_err <= 1'b1;
            end else if (req_opcode_i == OP_ALLOC) begin
              r_core_is_free <= 1'b0;
              if (w_aligned[DATA_W]) begin
                r_rsp_err  <= 1'b1;
                r_rsp_data <= ALL_ONES;
              end else begin
                r_core_arg <= w_aligned[DATA_W-1:0];
              end
            end else if (req_opcode_i == OP_FREE) begin
              r_core_is_free <= 1'b1;
              r_core_arg     <= req_data_i;
            end else begin
              r_rsp_err <= 1'b1;
            end
          end
        end
        S_CORE_ISSUE, S_CORE_WAIT: begin
          // Done may coincide with the issue handshake; both states capture it.
          if (core_done_i && ((r_state == S_CORE_WAIT) || core_ready_i)) begin
            r_rsp_data <= core_result_i;
            r_rsp_err  <= !r_core_is_free && (core_result_i == ALL_ONES);
          end
        end
        default: ;
      endcase
    end
  end

  // Core update of reg 0 is applied last so it beats a same-cycle host write.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CFG_REGS; i++) r_cfg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CFG_REGS; i++) begin
        if (w_cfg_we && (w_idx == DATA_W'(i))) r_cfg[i] <= req_data_i;
      end
      if (cfg_flp_we_i) r_cfg[0] <= cfg_flp_i;
    end
  end

  for (genvar g = 0; g < NUM_CFG_REGS; g++) begin : g_cfg_out
    assign cfg_regs_o[g*DATA_W +: DATA_W] = r_cfg[g];
  end

  assign rsp_data_o     = r_rsp_data;
  assign rsp_err_o      = r_rsp_err;
  assign core_arg_o     = r_core_arg;
  assign core_is_free_o = r_core_is_free;

endmodule

// File: tb/tb_falafel_req_frontend.sv
// tb/tb_falafel_req_frontend.sv - self-checking bench for falafel_req_frontend
// Reference model is arithmetic over an array of config regs; honours FALAFEL_REQ_STATS_EN.
module tb_falafel_req_frontend;
  localparam logic [63:0] BASE = 64'h10;
  localparam logic [63:0] ONES = '1;

  logic         clk = 1'b0;
  logic         rst_ni, req_valid_i, req_we_i, rsp_ready_i, core_ready_i, core_done_i, cfg_flp_we_i;
  logic [63:0]  req_opcode_i, req_addr_i, req_data_i, core_result_i, cfg_flp_i;
  logic         req_ready_o, rsp_valid_o, rsp_err_o, core_valid_o, core_is_free_o;
  logic [63:0]  rsp_data_o, core_arg_o;
  logic [255:0] cfg_regs_o;

  always #5 clk = ~clk;

  falafel_req_frontend dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_opcode_i(req_opcode_i),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .core_valid_o(core_valid_o), .core_ready_i(core_ready_i), .core_is_free_o(core_is_free_o),
    .core_arg_o(core_arg_o), .core_done_i(core_done_i), .core_result_i(core_result_i),
    .cfg_regs_o(cfg_regs_o), .cfg_flp_we_i(cfg_flp_we_i), .cfg_flp_i(cfg_flp_i)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] m_cfg [4];
  logic [63:0] m_alloc_ok, m_free_ok, m_nomem;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_regs();
    for (int i = 0; i < 4; i++) check($sformatf("cfg_reg%0d", i), cfg_regs_o[i*64 +: 64], m_cfg[i]);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready_o, 1);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    check("rst_rsp_data", rsp_data_o, 0);
    check("rst_core_valid", core_valid_o, 0);
    check("rst_core_is_free", core_is_free_o, 0);
    check("rst_core_arg", core_arg_o, 0);
    check_regs();
  endtask

  // One complete request: drive, model, serve the core side, drain the response.
  task automatic do_req(input logic [63:0] op, input logic [63:0] addr, input logic we,
                        input logic [63:0] data, input int rdy_dly, input int done_dly,
                        input logic [63:0] result, input int rsp_dly,
                        input logic flp_we, input logic [63:0] flp);
    logic        issue, is_free, eerr, addr_ok;
    logic [63:0] arg, edata, idx;
    logic [64:0] s, t;
    int          kind, n;
    issue = 0; is_free = 0; eerr = 0; arg = 0; edata = 0; kind = 0;
    addr_ok = (addr >= BASE) && ((addr - BASE) % 8 == 0);
    idx = (addr - BASE) / 8;
    if (op == 0) begin
      if (addr_ok && idx < 4) begin
        if (!we) edata = m_cfg[idx[1:0]];
        else     m_cfg[idx[1:0]] = data;
      end
`ifdef FALAFEL_REQ_STATS_EN
      else if (addr_ok && idx < 7) begin
        if (we) eerr = 1;
        else edata = (idx == 4) ? m_alloc_ok : (idx == 5) ? m_free_ok : m_nomem;
      end
`endif
      else eerr = 1;
    end else if (op == 1) begin
      kind = 1;
      s = (data < 64'd32) ? 65'd32 : {1'b0, data};
      t = ((s + 65'd7) / 65'd8) * 65'd8;
      if (t > {1'b0, ONES}) begin eerr = 1; edata = ONES; end
      else begin issue = 1; arg = t[63:0]; end
    end else if (op == 2) begin
      kind = 2; is_free = 1;
      if (data != 0) begin issue = 1; arg = data; end
    end else begin
      eerr = 1;
    end
    if (flp_we) m_cfg[0] = flp;

    @(negedge clk);
    check("req_ready_idle", req_ready_o, 1);
    req_valid_i = 1; req_opcode_i = op; req_addr_i = addr; req_we_i = we; req_data_i = data;
    cfg_flp_we_i = flp_we; cfg_flp_i = flp;
    @(negedge clk);
    req_valid_i = 0; cfg_flp_we_i = 0;
    check("core_valid_after_accept", core_valid_o, issue);
    check("rsp_valid_after_accept", rsp_valid_o, !issue);
    if (issue) begin
      check("core_arg", core_arg_o, arg);
      check("core_is_free", core_is_free_o, is_free);
      for (int c = 0; c < rdy_dly; c++) begin
        @(negedge clk);
        check("core_valid_hold", core_valid_o, 1);
        check("core_arg_stable", core_arg_o, arg);
      end
      core_ready_i = 1;
      if (done_dly == 0) begin core_done_i = 1; core_result_i = result; end
      @(negedge clk);
      core_ready_i = 0; core_done_i = 0;
      if (done_dly > 0) begin
        check("core_valid_dropped", core_valid_o, 0);
        for (int c = 1; c < done_dly; c++) @(negedge clk);
        core_done_i = 1; core_result_i = result;
        @(negedge clk);
        core_done_i = 0;
      end
      edata = result;
      eerr = !is_free && (result == ONES);
    end
    n = 0;
    while (!rsp_valid_o && n < 20) begin @(negedge clk); n++; end
    check("rsp_valid", rsp_valid_o, 1);
    check("rsp_data", rsp_data_o, edata);
    check("rsp_err", rsp_err_o, eerr);
    for (int c = 0; c < rsp_dly; c++) begin
      @(negedge clk);
      check("rsp_hold_valid", rsp_valid_o, 1);
      check("rsp_hold_data", rsp_data_o, edata);
      check("rsp_hold_err", rsp_err_o, eerr);
      check("rsp_hold_req_ready", req_ready_o, 0);
    end
    rsp_ready_i = 1;
    @(negedge clk);
    rsp_ready_i = 0;
    check("rsp_valid_after_hs", rsp_valid_o, 0);
    if (kind == 2) m_free_ok++;
    else if (kind == 1 && eerr) m_nomem++;
    else if (kind == 1) m_alloc_ok++;
    check_regs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] op, addr, data, res, v;
    int          sel, r;
    rst_ni = 0; req_valid_i = 0; req_we_i = 0; rsp_ready_i = 0; core_ready_i = 0;
    core_done_i = 0; cfg_flp_we_i = 0; req_opcode_i = 0; req_addr_i = 0; req_data_i = 0;
    core_result_i = 0; cfg_flp_i = 0;
    for (int i = 0; i < 4; i++) m_cfg[i] = 0;
    m_alloc_ok = 0; m_free_ok = 0; m_nomem = 0;
    repeat (3) @(negedge clk);
    rst_ni = 1;
    check_reset_outputs();

    do_req(0, 64'h10, 1, 64'h1000, 0, 0, 0, 0, 0, 0);
    check("flp_after_write", cfg_regs_o[63:0], 64'h1000);
    do_req(0, 64'h10, 0, 0, 0, 0, 0, 0, 0, 0);
    do_req(1, 0, 0, 64'd5, 0, 1, 64'h100, 0, 0, 0);
    do_req(1, 0, 0, 64'd33, 1, 0, 64'h140, 1, 0, 0);
    do_req(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0, 0);
    do_req(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 64'h8000, 0, 0, 0);
    do_req(1, 0, 0, 64'd40, 3, 2, 64'h2000, 0, 0, 0);
    do_req(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_req(2, 0, 0, 64'h2000, 0, 1, 0, 0, 0, 0);
    do_req(0, 64'h30, 0, 0, 0, 0, 0, 0, 0, 0);
    do_req(7, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    do_req(0, 64'h28, 1, 64'hBEEF, 0, 0, 0, 0, 0, 0);
    do_req(0, 64'h14, 1, 64'h1234, 0, 0, 0, 0, 0, 0);
    do_req(0, 64'h08, 1, 64'h1234, 0, 0, 0, 0, 0, 0);
    do_req(0, 64'h10, 1, 64'h5555, 0, 0, 0, 0, 1, 64'hABCD);
    do_req(1, 0, 0, 64'd100, 0, 0, ONES, 0, 0, 0);
    do_req(2, 0, 0, 64'h3000, 2, 3, 0, 0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 9);
      op = 0; addr = 0; data = {$urandom(), $urandom()}; res = 0;
      if (sel <= 2 || sel == 9) begin
        r = $urandom_range(0, 9);
        if (r <= 7)      addr = BASE + 64'(8 * r);
        else if (r == 8) addr = BASE + 64'(8 * $urandom_range(0, 3)) + 64'($urandom_range(1, 7));
        else             addr = 64'($urandom_range(0, 15));
      end else if (sel <= 5) begin
        op = 1;
        r = $urandom_range(0, 2);
        if (r == 0)      data = 64'($urandom_range(0, 100));
        else if (r == 1) data = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        res = ($urandom_range(0, 3) == 0) ? ONES : ({$urandom(), $urandom()} & ~64'h7);
      end else if (sel <= 7) begin
        op = 2;
        if ($urandom_range(0, 2) == 0) data = 0;
      end else begin
        op = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(3, 100)) : {$urandom(), $urandom()} | 64'h8;
      end
      if (sel == 9) do_req(0, BASE, 1, data, 0, 0, 0, 0, 1, {$urandom(), $urandom()});
      else do_req(op, addr, 1'($urandom_range(0, 1)), data, $urandom_range(0, 3),
                  $urandom_range(0, 3), res, $urandom_range(0, 2), 0, 0);
      if ($urandom_range(0, 4) == 0) begin
        v = {$urandom(), $urandom()};
        @(negedge clk);
        cfg_flp_we_i = 1; cfg_flp_i = v;
        @(negedge clk);
        cfg_flp_we_i = 0;
        m_cfg[0] = v;
        check("flp_idle_update", cfg_regs_o[63:0], v);
      end
    end

    do_req(0, 64'h18, 1, 64'hCAFE, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    req_valid_i = 1; req_opcode_i = 1; req_data_i = 64'd100; req_we_i = 0;
    @(negedge clk);
    req_valid_i = 0;
    check("midrst_issue", core_valid_o, 1);
    core_ready_i = 1;
    @(negedge clk);
    core_ready_i = 0;
    check("midrst_wait_core_valid", core_valid_o, 0);
    check("midrst_wait_rsp_valid", rsp_valid_o, 0);
    rst_ni = 0;
    @(negedge clk);
    rst_ni = 1;
    for (int i = 0; i < 4; i++) m_cfg[i] = 0;
    check_reset_outputs();
    core_done_i = 1; core_result_i = 64'h3000;
    @(negedge clk);
    core_done_i = 0;
    for (int c = 0; c < 3; c++) begin
      check("post_rst_no_rsp", rsp_valid_o, 0);
      check("post_rst_req_ready", req_ready_o, 1);
      @(negedge clk);
    end
    do_req(0, 64'h18, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
